// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, address field positions and lock encoding for the SRAM arbiter
package sram_pkg;

    localparam int DATA_W_DEF = 256;
    localparam int ADDR_W_DEF = 23;

    localparam int BANK_LSB = 0;
    localparam int BANK_MSB = 4;
    localparam int IDX_LSB  = 5;
    localparam int IDX_MSB  = 22;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/sram_rr_grant.sv
// rtl/sram_rr_grant.sv - combinational two-way round-robin grant with burst lock
module sram_rr_grant
    import sram_pkg::*;
(
    input  logic        valid0,
    input  logic        valid1,
    input  lock_state_t lock_state,
    input  logic        owner,
    input  logic        last_grant,
    output logic        grant_valid,
    output logic        grant
);

    logic owner_valid;

    always_comb begin
        owner_valid = owner ? valid1 : valid0;
        grant_valid = valid0 | valid1;
        grant       = 1'b0;
        if (lock_state == LOCKED && owner_valid) begin
            grant = owner;
        end else if (valid0 && valid1) begin
            grant = ~last_grant;
        end else begin
            // Single requester (or none, which leaves port 0 selected for the muxes)
            grant = valid1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter with burst locking for a single-port SRAM
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    lock_state_t      lock_state;
    logic             owner;
    logic [CNT_W-1:0] beat_cnt;
    logic             last_grant;
    logic             rd_pend;
    logic             rd_port;

    logic             fire;
    logic             grant;
    logic             sel_we;
    logic             owner_valid;
    logic [CNT_W-1:0] next_cnt;

    sram_rr_grant u_grant (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .lock_state  (lock_state),
        .owner       (owner),
        .last_grant  (last_grant),
        .grant_valid (fire),
        .grant       (grant)
    );

    always_comb begin
        owner_valid = owner ? req1_valid : req0_valid;
        next_cnt    = beat_cnt + CNT_W'(1);
        sel_we      = grant ? req1_we : req0_we;
        req0_ready  = fire & ~grant;
        req1_ready  = fire & grant;
        sram_we     = fire & sel_we;
        sram_addr   = grant ? req1_addr : req0_addr;
        sram_wdata  = grant ? req1_wdata : req0_wdata;
        rsp0_valid  = rd_pend & ~rd_port;
        rsp1_valid  = rd_pend & rd_port;
        rsp_rdata   = sram_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_state <= IDLE;
            owner      <= 1'b0;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_port    <= 1'b0;
        end else begin
            rd_pend <= fire & ~sel_we;
            if (fire && !sel_we) begin
                rd_port <= grant;
            end
            // Owner dropped valid: release; a grant to the other port below takes over this same edge
            if (lock_state == LOCKED && !owner_valid) begin
                lock_state <= IDLE;
                last_grant <= owner;
            end
            if (fire) begin
                if (lock_state == IDLE || grant != owner) begin
                    owner    <= grant;
                    beat_cnt <= CNT_W'(1);
                    if (BURST_MAX > 1) begin
                        lock_state <= LOCKED;
                    end else begin
                        lock_state <= IDLE;
                        last_grant <= grant;
                    end
                end else begin
                    beat_cnt <= next_cnt;
                    if (next_cnt == CNT_W'(BURST_MAX)) begin
                        lock_state <= IDLE;
                        last_grant <= owner;
                    end
                end
            end
        end
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port 256-bit SRAM macro between two requesters (port 0, port 1) using valid/ready request handshakes.
- Round-robin arbitration with burst locking: the current owner keeps the SRAM for up to BURST_MAX consecutive beats while it holds valid, then priority rotates.
- Drives the SRAM address, write-data and write-enable inputs.
- Routes the SRAM's 1-cycle-latency read data back to the requester that issued the read.

Parameters:
DATA_W, 256, SRAM word width
ADDR_W, 23, SRAM address width (bits [4:0] bank select, [22:5] in-bank index, passed through untouched)
BURST_MAX, 4, maximum consecutive granted beats per ownership (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted this cycle
req0_we  input  1  port 0 write (1) / read (0)
req0_addr  input  ADDR_W  port 0 address
req0_wdata  input  DATA_W  port 0 write data
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata: same as port 0, for port 1
rsp0_valid  output  1  port 0 read data valid (no backpressure)
rsp1_valid  output  1  port 1 read data valid (no backpressure)
rsp_rdata  output  DATA_W  read data, shared by both ports, qualified by rspN_valid
sram_addr  output  ADDR_W  to SRAM address
sram_wdata  output  DATA_W  to SRAM data_in
sram_we  output  1  to SRAM write_en
sram_rdata  input  DATA_W  from SRAM data_out

Behaviour:
- State registers: lock_state {IDLE, LOCKED}, owner (1b), beat_cnt (ceil(log2(BURST_MAX+1)) bits), last_grant (1b round-robin pointer), rd_pend (1b), rd_port (1b).
- Reset (rst low, asynchronous): lock_state=IDLE, owner=0, beat_cnt=0, last_grant=1 (port 0 wins the first contention), rd_pend=0, rd_port=0. Consequently rsp0_valid=rsp1_valid=0.
- Grant g, combinational each cycle:
  - LOCKED and reqOWNER_valid: g=owner.
  - Otherwise both valid: g=~last_grant.
  - Otherwise the single valid port.
  - No valid: no grant.
- reqN_ready = (g==N) and a grant exists. Ready never asserts without the matching valid.
- Fire = grant exists. SRAM outputs on fire: sram_addr/sram_wdata/sram_we are the granted port's fields, combinational, sampled by the SRAM on the same edge.
- No fire: sram_we=0; sram_addr/sram_wdata hold the port-0 fields (don't-care, but no X).
- Lock transitions on a fire edge:
  - IDLE or new owner: owner<=g, beat_cnt<=1. Go LOCKED if BURST_MAX>1; else stay IDLE with last_grant<=g.
  - LOCKED, g==owner: beat_cnt+1. When it reaches BURST_MAX: IDLE, last_grant<=owner.
- Lock release: LOCKED while reqOWNER_valid low -> IDLE, last_grant<=owner. That same cycle the other port may be granted combinationally, so there is no dead cycle.
- Read response latency = 1 cycle:
  - A read fire sets rd_pend<=1, rd_port<=g. Any other cycle clears rd_pend.
  - rsp0_valid = rd_pend & ~rd_port; rsp1_valid = rd_pend & rd_port.
  - rsp_rdata = sram_rdata, combinational pass-through.
- Back-to-back reads, including from alternating ports, produce back-to-back responses in issue order.
- Writes produce no response. A read after a write to the same address returns the new data.
- Throughput: one access per cycle when any request is pending.
- Reset mid-burst or with a read in flight: lock and pending read are discarded; that response is never delivered.
- The SRAM's own synchronous active-high reset is driven at top level from the inverted rst, so both blocks reset together.

Decomposition:
- Shared package sram_pkg holds DATA_W/ADDR_W defaults, the bank-select field positions ([4:0], [22:5]) and the lock_state encoding (IDLE=0, LOCKED=1).
- One natural sub-module: sram_rr_grant, the combinational two-way round-robin-with-lock grant selector.
- Response tracking stays inline.

Test Plan:
- Reset, then port 0 writes 0xA5..A5 to addr 0x000020, then reads it -> sram_we high for one cycle; rsp0_valid exactly 1 cycle after the read fire; rsp_rdata=0xA5..A5; rsp1_valid stays 0.
- Both ports hold valid continuously with BURST_MAX=4 -> grants are 0,0,0,0,1,1,1,1,0...; reqN_ready never overlap.
- Port 0 bursts 2 beats, drops valid while port 1 is valid -> port 1 is granted in the very next cycle with no idle cycle, and gets the full 4-beat burst.
- Alternating reads port 0 addr 0x21, port 1 addr 0x41 (pre-written 0x11.., 0x22..) -> rsp0_valid/rsp1_valid alternate each cycle with the matching data.
- Port 1 issues a read, rst pulses low before the next edge -> no rsp1_valid afterwards; after release both ports contending gives the first grant to port 0.
- BURST_MAX=1, both valid -> strict alternation every cycle starting with port 0.
